// File: rtl/accum_pkg.sv
// Shared definitions for the add/subtract accumulator: opcodes, FSM states
// and the saturation limits used when a result overflows.
package accum_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int MAX_WIDTH = 32;
    localparam logic [MAX_WIDTH-1:0] UNIT = MAX_WIDTH'(1);

    // Most negative signed value of the given width (1000...0).
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
        return UNIT << (width - 1);
    endfunction

    // Most positive signed value of the given width (0111...1).
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
        return sat_min(width) - UNIT;
    endfunction

endpackage

// File: rtl/accum_sub_unit_negate.sv
// Combinational two's-complement negation (~A + 1) with the carry out of
// the increment; the carry is set only when A is zero.
module twos_negate
    import accum_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] neg_o,
    output logic             carry_o
);

    // Invert the operand and add one, keeping the carry out of the top bit
    always_comb begin
        {carry_o, neg_o} = {1'b0, ~a_i} + {{WIDTH{1'b0}}, 1'b1};
    end

endmodule

// File: rtl/accum_sub_unit.sv
// Sequential signed add/subtract accumulator with valid/ready on both sides,
// optional saturation and a sticky overflow flag cleared only by CLR or reset.
module accum_sub_unit
    import accum_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    state_e           state_q, state_d;
    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic             accept;
    logic [WIDTH-1:0] negData;
    logic             negCarry;
    logic [WIDTH:0]   accExt, dataExt, sumExt;
    logic [WIDTH:0]   addRaw, subRaw;

    assign accept     = in_valid && in_ready;
    assign out_acc    = acc_q;
    assign out_carry  = carry_q;
    assign out_ovf    = ovf_q;
    assign ovf_sticky = sticky_q;

    twos_negate #(.WIDTH(WIDTH)) uNegate (
        .a_i     (data_q),
        .neg_o   (negData),
        .carry_o (negCarry)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, one cycle of EXEC, hold RESP until taken
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)    state_d = ST_EXEC;
            ST_EXEC:                state_d = ST_RESP;
            ST_RESP: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; both are held low while reset is applied
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_RESP) && !rst;
    end

    // Capture the operand and opcode when a request is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_ADD;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= op_e'(in_op);
            data_q <= in_data;
        end
    end

    // Arithmetic, overflow detection and saturation for the latched operation
    always_comb begin
        accExt   = {acc_q[WIDTH-1], acc_q};
        dataExt  = {data_q[WIDTH-1], data_q};
        addRaw   = {1'b0, acc_q} + {1'b0, data_q};
        subRaw   = {1'b0, acc_q} + {1'b0, negData};
        sumExt   = '0;
        acc_d    = acc_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        if (state_q == ST_EXEC) begin
            unique case (op_q)
                OP_ADD, OP_SUB: begin
                    if (op_q == OP_ADD) begin
                        sumExt  = accExt + dataExt;
                        carry_d = addRaw[WIDTH];
                    end else begin
                        sumExt  = accExt - dataExt;
                        carry_d = subRaw[WIDTH] | negCarry;
                    end
                    ovf_d    = sumExt[WIDTH] ^ sumExt[WIDTH-1];
                    sticky_d = sticky_q | ovf_d;
                    if (ovf_d && SATURATE) begin
                        acc_d = sumExt[WIDTH] ? SAT_MIN : SAT_MAX;
                    end else begin
                        acc_d = sumExt[WIDTH-1:0];
                    end
                end
                OP_LOAD: begin
                    acc_d   = data_q;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                OP_CLR: begin
                    acc_d    = '0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    sticky_d = 1'b0;
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    // Result registers; they only change at the end of EXEC so RESP holds them stable
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_accum_sub_unit.sv
// Testbench for accum_sub_unit: a wrapping and a saturating instance run in
// lockstep against an integer-arithmetic reference model.
module tb_accum_sub_unit;

    localparam int W    = 4;
    localparam int MAXV = 2 ** (W - 1) - 1;
    localparam int MINV = -(2 ** (W - 1));

    logic         clk;
    logic         rst;
    logic         inValid;
    logic [1:0]   inOp;
    logic [W-1:0] inData;
    logic         outReady;
    logic         inReady0, inReady1;
    logic         outValid0, outValid1;
    logic [W-1:0] acc0, acc1;
    logic         carry0, carry1;
    logic         ovf0, ovf1;
    logic         sticky0, sticky1;

    int totalChecks = 0;
    int badChecks   = 0;

    int refAcc0, refAcc1;
    bit refSticky0, refSticky1;
    bit refCarry0, refCarry1;
    bit refOvf0, refOvf1;

    logic         pendValid;
    logic [1:0]   pendOp;
    logic [W-1:0] pendData;

    accum_sub_unit #(.WIDTH(W), .SATURATE(1'b0)) dutWrap (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady0),
        .in_op      (inOp),
        .in_data    (inData),
        .out_valid  (outValid0),
        .out_ready  (outReady),
        .out_acc    (acc0),
        .out_carry  (carry0),
        .out_ovf    (ovf0),
        .ovf_sticky (sticky0)
    );

    accum_sub_unit #(.WIDTH(W), .SATURATE(1'b1)) dutSat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady1),
        .in_op      (inOp),
        .in_data    (inData),
        .out_valid  (outValid1),
        .out_ready  (outReady),
        .out_acc    (acc1),
        .out_carry  (carry1),
        .out_ovf    (ovf1),
        .ovf_sticky (sticky1)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: signed integer arithmetic with range checks
    task automatic modelStep(input bit sat, input logic [1:0] op, input logic [W-1:0] data,
                             inout int acc, inout bit sticky, output bit carry, output bit ovf);
        int aU, aS, accU, r;
        aU    = int'(data);
        aS    = (aU > MAXV) ? aU - 2 ** W : aU;
        accU  = (acc < 0) ? acc + 2 ** W : acc;
        carry = 1'b0;
        ovf   = 1'b0;
        r     = 0;
        case (op)
            2'b00: begin r = acc + aS; carry = (accU + aU) >= 2 ** W; end
            2'b01: begin r = acc - aS; carry = (accU >= aU);          end
            2'b10: r = aS;
            default: r = 0;
        endcase
        if (op == 2'b00 || op == 2'b01) begin
            ovf = (r > MAXV) || (r < MINV);
            if (ovf) begin
                if (sat) r = (r > MAXV) ? MAXV : MINV;
                else     r = (r > MAXV) ? r - 2 ** W : r + 2 ** W;
            end
            sticky = sticky | ovf;
        end
        if (op == 2'b11) sticky = 1'b0;
        acc = r;
    endtask

    task automatic checkResult(input string tag);
        logic [W-1:0] e0, e1;
        e0 = refAcc0[W-1:0];
        e1 = refAcc1[W-1:0];
        checkOutput({tag, "Valid0"},  32'(outValid0), 32'd1);
        checkOutput({tag, "Valid1"},  32'(outValid1), 32'd1);
        checkOutput({tag, "Acc0"},    32'(acc0),      32'(e0));
        checkOutput({tag, "Acc1"},    32'(acc1),      32'(e1));
        checkOutput({tag, "Carry0"},  32'(carry0),    32'(refCarry0));
        checkOutput({tag, "Carry1"},  32'(carry1),    32'(refCarry1));
        checkOutput({tag, "Ovf0"},    32'(ovf0),      32'(refOvf0));
        checkOutput({tag, "Ovf1"},    32'(ovf1),      32'(refOvf1));
        checkOutput({tag, "Sticky0"}, 32'(sticky0),   32'(refSticky0));
        checkOutput({tag, "Sticky1"}, 32'(sticky1),   32'(refSticky1));
    endtask

    // One full transaction, starting and ending on a falling edge
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] data, input int hold);
        int waitCnt;
        inValid = 1'b1;
        inOp    = op;
        inData  = data;
        checkOutput("readyBeforeAccept", 32'(inReady0), 32'd1);
        waitCnt = 0;
        while (!inReady0 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        @(posedge clk);
        @(negedge clk);
        inValid = pendValid;
        inOp    = pendOp;
        inData  = pendData;
        checkOutput("execValid", 32'(outValid0), 32'd0);
        checkOutput("execReady", 32'(inReady0),  32'd0);
        modelStep(1'b0, op, data, refAcc0, refSticky0, refCarry0, refOvf0);
        modelStep(1'b1, op, data, refAcc1, refSticky1, refCarry1, refOvf1);
        @(negedge clk);
        checkResult("resp");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkResult("hold");
            checkOutput("holdReady", 32'(inReady0), 32'd0);
        end
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("postValid", 32'(outValid0), 32'd0);
        checkOutput("postReady", 32'(inReady0),  32'd1);
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        repeat (cycles) @(negedge clk);
        checkOutput("rstReady",  32'(inReady0),  32'd0);
        checkOutput("rstValid",  32'(outValid0), 32'd0);
        checkOutput("rstAcc0",   32'(acc0),      32'd0);
        checkOutput("rstAcc1",   32'(acc1),      32'd0);
        checkOutput("rstCarry",  32'(carry0),    32'd0);
        checkOutput("rstOvf",    32'(ovf0),      32'd0);
        checkOutput("rstSticky", 32'(sticky0),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstReleaseReady", 32'(inReady0), 32'd1);
        refAcc0 = 0; refAcc1 = 0;
        refSticky0 = 1'b0; refSticky1 = 1'b0;
    endtask

    // Main sequence: directed cases, backpressure, reset mid-op, random ops
    initial begin
        rst       = 1'b1;
        inValid   = 1'b0;
        inOp      = 2'b00;
        inData    = '0;
        outReady  = 1'b0;
        pendValid = 1'b0;
        pendOp    = 2'b00;
        pendData  = '0;
        refAcc0 = 0; refAcc1 = 0;
        refSticky0 = 1'b0; refSticky1 = 1'b0;

        doReset(2);

        applyStimulus(2'b10, 4'd4, 0);
        checkOutput("load4Acc", 32'(acc0), 32'h4);
        applyStimulus(2'b01, 4'd7, 0);
        checkOutput("sub7Acc",   32'(acc0),   32'hd);
        checkOutput("sub7Carry", 32'(carry0), 32'd0);

        applyStimulus(2'b10, 4'd7, 0);
        applyStimulus(2'b00, 4'd7, 0);
        checkOutput("add7Wrap",   32'(acc0),    32'he);
        checkOutput("add7Sat",    32'(acc1),    32'h7);
        checkOutput("add7Sticky", 32'(sticky0), 32'd1);
        applyStimulus(2'b11, 4'd0, 0);
        checkOutput("clrAcc",    32'(acc0),    32'h0);
        checkOutput("clrSticky", 32'(sticky0), 32'd0);

        applyStimulus(2'b01, 4'b1000, 0);
        checkOutput("subMinWrap",  32'(acc0),   32'h8);
        checkOutput("subMinOvf",   32'(ovf0),   32'd1);
        checkOutput("subMinCarry", 32'(carry0), 32'd0);
        checkOutput("subMinSat",   32'(acc1),   32'h7);

        pendValid = 1'b1;
        pendOp    = 2'b00;
        pendData  = 4'd2;
        applyStimulus(2'b10, 4'd3, 5);
        pendValid = 1'b0;
        applyStimulus(2'b00, 4'd2, 0);
        checkOutput("pendingAcc", 32'(acc0), 32'h5);

        inValid = 1'b1;
        inOp    = 2'b00;
        inData  = 4'd3;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        checkOutput("midRstValid", 32'(outValid0), 32'd0);
        checkOutput("midRstAcc0",  32'(acc0),      32'd0);
        checkOutput("midRstAcc1",  32'(acc1),      32'd0);
        checkOutput("midRstReady", 32'(inReady0),  32'd0);
        rst = 1'b0;
        refAcc0 = 0; refAcc1 = 0;
        refSticky0 = 1'b0; refSticky1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("noRespAfterRst", 32'(outValid0), 32'd0);
            checkOutput("idleAfterRst",   32'(inReady0),  32'd1);
        end
        applyStimulus(2'b00, 4'd2, 0);
        checkOutput("addAfterRst", 32'(acc0), 32'h2);

        for (int n = 0; n < 80; n++) begin
            logic [1:0]   rOp;
            logic [W-1:0] rData;
            rOp   = 2'($urandom_range(0, 3));
            rData = W'($urandom);
            applyStimulus(rOp, rData, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "[TB] time limit reached");
    end

endmodule
